// File: rtl/serial_addsub_seq_if.sv
// Operand/control and result bundle for the nibble-serial add/sub sequencer.
// The master side drives the request and operands; the slave side returns status and result.
interface serial_addsub_seq_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         start;
   logic         x;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;
   logic         v;

   modport master (
      output start, x, a, b,
      input  busy, done, s, cout, v
   );

   modport slave (
      input  start, x, a, b,
      output busy, done, s, cout, v
   );
endinterface

// File: rtl/serial_addsub_seq.sv
// Nibble-serial add/subtract: one 4-bit ripple slice per clock, LSB nibble first.
// x=0 gives a+b, x=1 gives b+~a+1; s/cout/v update only when a result completes.
module serial_addsub_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   serial_addsub_seq_if.slave  io_bus
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         r_state;
   state_e         w_state_d;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic           r_x;
   logic           r_carry;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_part;
   logic [W-1:0]   r_s;
   logic           r_cout;
   logic           r_v;

   logic [3:0]     w_sa;
   logic [3:0]     w_sb;
   logic [3:0]     w_sum;
   logic           w_c1;
   logic           w_c2;
   logic           w_c3;
   logic           w_c4;
   logic [W-1:0]   w_a_shift;
   logic [W-1:0]   w_b_shift;
   logic [W-1:0]   w_part_next;
   logic           w_capture;
   logic           w_run;
   logic           w_last;

   // 4-bit ripple slice; w_c3 is the carry into the slice MSB, needed for overflow
   assign w_sa     = r_a[3:0] ^ {4{r_x}};
   assign w_sb     = r_b[3:0];
   assign w_sum[0] = w_sa[0] ^ w_sb[0] ^ r_carry;
   assign w_c1     = (w_sa[0] & w_sb[0]) | (r_carry & (w_sa[0] ^ w_sb[0]));
   assign w_sum[1] = w_sa[1] ^ w_sb[1] ^ w_c1;
   assign w_c2     = (w_sa[1] & w_sb[1]) | (w_c1 & (w_sa[1] ^ w_sb[1]));
   assign w_sum[2] = w_sa[2] ^ w_sb[2] ^ w_c2;
   assign w_c3     = (w_sa[2] & w_sb[2]) | (w_c2 & (w_sa[2] ^ w_sb[2]));
   assign w_sum[3] = w_sa[3] ^ w_sb[3] ^ w_c3;
   assign w_c4     = (w_sa[3] & w_sb[3]) | (w_c3 & (w_sa[3] ^ w_sb[3]));

   generate
      if (NIBBLES > 1) begin : g_wide
         assign w_a_shift   = {4'b0000, r_a[W-1:4]};
         assign w_b_shift   = {4'b0000, r_b[W-1:4]};
         assign w_part_next = {w_sum, r_part[W-1:4]};
      end else begin : g_narrow
         assign w_a_shift   = '0;
         assign w_b_shift   = '0;
         assign w_part_next = w_sum;
      end
   endgenerate

   assign w_run     = (r_state == StRun);
   assign w_last    = (r_cnt == CW'(NIBBLES - 1));
   assign w_capture = io_bus.start && (r_state != StRun);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (io_bus.start) w_state_d = StRun;
         StRun:   if (w_last) w_state_d = StDone;
         StDone:  w_state_d = io_bus.start ? StRun : StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_x     <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_part  <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_v     <= 1'b0;
      end else if (w_capture) begin
         r_a     <= io_bus.a;
         r_b     <= io_bus.b;
         r_x     <= io_bus.x;
         r_carry <= io_bus.x;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_a     <= w_a_shift;
         r_b     <= w_b_shift;
         r_carry <= w_c4;
         r_part  <= w_part_next;
         if (w_last) begin
            r_s    <= w_part_next;
            r_cout <= w_c4;
            r_v    <= w_c3 ^ w_c4;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign io_bus.busy = w_run;
   assign io_bus.done = (r_state == StDone);
   assign io_bus.s    = r_s;
   assign io_bus.cout = r_cout;
   assign io_bus.v    = r_v;
endmodule
